// File: rtl/iod_train_pkg.sv
// Shared types and constants for the IOD eye-training sequencer.
package iod_train_pkg;
  localparam int   TAP_W_DEF = 7;
  localparam logic DIR_INC   = 1'b1;
  localparam logic DIR_DEC   = 1'b0;

  typedef enum logic [3:0] {
    IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, RETURN, PARK, NEXT, DONE
  } state_e;
endpackage

// File: rtl/iod_eye_window_tracker.sv
// Tracks the passing-window start/end for the lane under training and
// derives the window width check and the centre tap.
module iod_eye_window_tracker
  import iod_train_pkg::*;
#(
  parameter int TAP_W   = TAP_W_DEF,
  parameter int MIN_EYE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             hit,
  input  logic             close,
  input  logic [TAP_W-1:0] tap,
  input  logic [TAP_W-1:0] end_tap,
  output logic             found,
  output logic             width_ok,
  output logic [TAP_W-1:0] center
);
  logic             found_q, found_d;
  logic [TAP_W-1:0] start_q, start_d;
  logic [TAP_W-1:0] end_q, end_d;
  logic [TAP_W:0]   sum, width;

  always_comb begin
    found_d = found_q;
    start_d = start_q;
    end_d   = end_q;
    if (load) begin
      found_d = 1'b0;
      start_d = '0;
      end_d   = '0;
    end else begin
      // first passing tap opens the window; later passes leave start alone
      if (hit && !found_q) begin
        found_d = 1'b1;
        start_d = tap;
      end
      if (close) end_d = end_tap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      found_q <= 1'b0;
      start_q <= '0;
      end_q   <= '0;
    end else begin
      found_q <= found_d;
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  // one extra bit so a full-range window (0..max) neither wraps nor overflows
  assign sum      = {1'b0, start_q} + {1'b0, end_q};
  assign width    = {1'b0, end_q} - {1'b0, start_q} + (TAP_W+1)'(1);
  assign width_ok = (width >= (TAP_W+1)'(MIN_EYE));
  assign center   = sum[TAP_W:1];
  assign found    = found_q;
endmodule

// File: rtl/iod_eye_train_ctrl.sv
// Sequential per-lane delay-line sweep: find the eye-monitor passing window
// on each IOD lane and park the delay line at its centre.
module iod_eye_train_ctrl
  import iod_train_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int TAP_W      = TAP_W_DEF,
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CYC = 16,
  parameter int MIN_EYE    = 4
) (
  input  logic                       FAB_CLK,
  input  logic                       SYNC_RST,
  input  logic                       TRAIN_START,
  output logic                       TRAIN_BUSY,
  output logic                       TRAIN_DONE,
  output logic [NUM_LANES-1:0]       LANE_FAIL,
  output logic [NUM_LANES*TAP_W-1:0] LANE_CENTER,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_MX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int CNT_W  = $clog2(CNT_MX + 1);
  localparam logic [TAP_W-1:0] TAP_MAX = '1;

  state_e                     state_q, state_d;
  logic [LANE_W-1:0]          lane_q, lane_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       bad_q, bad_d, ph_q, ph_d;
  logic [NUM_LANES-1:0]       fail_q, fail_d;
  logic [NUM_LANES*TAP_W-1:0] center_q, center_d;

  logic [NUM_LANES-1:0] lane_oh;
  logic                 load_en, move_en, dir_en, clr_en;
  logic                 trk_hit, trk_close, found, width_ok;
  logic [TAP_W-1:0]     trk_end, center;
  logic                 pass, at_end;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_oh
    assign lane_oh[i] = (lane_q == LANE_W'(i));
  end

  assign pass   = !bad_q;
  assign at_end = (tap_q == TAP_MAX) || |(DELAY_LINE_OUT_OF_RANGE & lane_oh);

  iod_eye_window_tracker #(.TAP_W(TAP_W), .MIN_EYE(MIN_EYE)) u_trk (
    .clk(FAB_CLK), .rst(SYNC_RST), .load(state_q == LOAD),
    .hit(trk_hit), .close(trk_close), .tap(tap_q), .end_tap(trk_end),
    .found(found), .width_ok(width_ok), .center(center)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    tap_d     = tap_q;
    cnt_d     = cnt_q;
    bad_d     = bad_q;
    ph_d      = ph_q;
    fail_d    = fail_q;
    center_d  = center_q;
    load_en   = 1'b0;
    move_en   = 1'b0;
    dir_en    = DIR_DEC;
    clr_en    = 1'b0;
    trk_hit   = 1'b0;
    trk_close = 1'b0;
    trk_end   = tap_q;
    unique case (state_q)
      IDLE: if (TRAIN_START) begin
        fail_d   = '0;
        center_d = '0;
        lane_d   = '0;
        state_d  = LOAD;
      end
      LOAD: begin
        load_en = 1'b1;
        tap_d   = '0;
        state_d = CLEAR;
      end
      CLEAR: begin
        clr_en  = 1'b1;
        bad_d   = 1'b0;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC-1)) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      SAMPLE: begin
        bad_d = bad_q | |((EYE_MONITOR_EARLY | EYE_MONITOR_LATE) & lane_oh);
        if (cnt_q == CNT_W'(SAMPLE_CYC-1)) state_d = EVAL;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      EVAL: begin
        trk_hit = pass;
        ph_d    = 1'b0;
        // a failing tap always wins over the range limit
        if (!pass && found) begin
          trk_close = 1'b1;
          trk_end   = tap_q - TAP_W'(1);
          state_d   = RETURN;
        end else if (pass && at_end) begin
          trk_close = 1'b1;
          state_d   = RETURN;
        end else if (!pass && at_end) state_d = PARK;
        else state_d = STEP;
      end
      STEP: begin
        move_en = 1'b1;
        dir_en  = DIR_INC;
        tap_d   = tap_q + TAP_W'(1);
        state_d = CLEAR;
      end
      RETURN: begin
        if (!width_ok) state_d = PARK;
        else if (tap_q == center) begin
          for (int i = 0; i < NUM_LANES; i++)
            if (lane_oh[i]) center_d[i*TAP_W +: TAP_W] = center;
          state_d = NEXT;
        end else begin
          // walk back with a gap cycle between pulses
          ph_d = !ph_q;
          if (!ph_q) begin
            move_en = 1'b1;
            tap_d   = tap_q - TAP_W'(1);
          end
        end
      end
      PARK: begin
        load_en = 1'b1;
        tap_d   = '0;
        fail_d  = fail_q | lane_oh;
        for (int i = 0; i < NUM_LANES; i++)
          if (lane_oh[i]) center_d[i*TAP_W +: TAP_W] = '0;
        state_d = NEXT;
      end
      NEXT: begin
        if (lane_q == LANE_W'(NUM_LANES-1)) state_d = DONE;
        else begin
          lane_d  = lane_q + LANE_W'(1);
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      tap_q    <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      ph_q     <= 1'b0;
      fail_q   <= '0;
      center_q <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      tap_q    <= tap_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      ph_q     <= ph_d;
      fail_q   <= fail_d;
      center_q <= center_d;
    end
  end

  assign TRAIN_BUSY              = (state_q != IDLE) && (state_q != DONE);
  assign TRAIN_DONE              = (state_q == DONE);
  assign LANE_FAIL               = fail_q;
  assign LANE_CENTER             = center_q;
  assign DELAY_LINE_LOAD         = {NUM_LANES{load_en}} & lane_oh;
  assign DELAY_LINE_MOVE         = {NUM_LANES{move_en}} & lane_oh;
  assign DELAY_LINE_DIRECTION    = {NUM_LANES{move_en & dir_en}} & lane_oh;
  assign EYE_MONITOR_CLEAR_FLAGS = {NUM_LANES{clr_en}} & lane_oh;
endmodule
